// File: rtl/alarm_trigger.sv
// Alarm trigger: latches the BCD alarm time, compares it against the running
// clock and runs the IDLE/ARMED/RINGING/SNOOZE state machine that drives the
// buzzer and the status flags for display and LED logic.
module alarm_trigger #(
    parameter int unsigned SNOOZE_MIN       = 9,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       alarm_enable,
    input  logic       load_alarm,
    input  logic [3:0] min_set,
    input  logic [3:0] minten_set,
    input  logic [3:0] hour_set,
    input  logic [3:0] hourten_set,
    input  logic [3:0] min,
    input  logic [3:0] minten,
    input  logic [3:0] hour,
    input  logic [3:0] hourten,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozed,
    output logic [1:0] snooze_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] RINGING = 2'd2;
    localparam logic [1:0] SNOOZE  = 2'd3;

    localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_MIN * 60);
    localparam logic [9:0] RING_LAST = 10'(RING_TIMEOUT_SEC - 1);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

    logic [1:0]  state_q, state_d;
    logic [15:0] alarm_q, alarm_d;
    logic        valid_q, valid_d;
    logic        load_prev_q;
    logic        match_prev_q;
    logic [9:0]  ring_cnt_q, ring_cnt_d;
    logic [9:0]  snz_cnt_q, snz_cnt_d;
    logic        beep_q, beep_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        buzzer_q, ringing_q, snoozed_q;

    logic load_rise;
    logic match;
    logic match_edge;

    assign load_rise  = load_alarm & ~load_prev_q;
    // Compare against the stored alarm; a load in the same cycle takes effect next cycle.
    assign match      = valid_q && (alarm_q == {hourten, hour, minten, min});
    // Only the first matching cycle triggers, so a dismissed alarm stays quiet for the rest of that minute.
    assign match_edge = match & ~match_prev_q;

    // Next-state and counter logic, prioritised enable > load > dismiss > snooze > tick.
    always_comb begin
        state_d    = state_q;
        alarm_d    = alarm_q;
        valid_d    = valid_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        beep_d     = beep_q;
        cnt_d      = cnt_q;

        if (load_rise) begin
            alarm_d = {hourten_set, hour_set, minten_set, min_set};
            valid_d = 1'b1;
        end

        if (!alarm_enable) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else if (load_rise) begin
            // A fresh alarm time restarts the event from scratch.
            state_d = ARMED;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_q) state_d = ARMED;
                end
                ARMED: begin
                    if (match_edge) begin
                        state_d    = RINGING;
                        ring_cnt_d = 10'd0;
                        beep_d     = 1'b1;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state_d = ARMED;
                        cnt_d   = 2'd0;
                    end else if (snooze && (cnt_q < SNZ_MAX)) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = SNZ_LOAD;
                        cnt_d     = cnt_q + 2'd1;
                    end else if (tick_1hz) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d = ARMED;
                            cnt_d   = 2'd0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 10'd1;
                            beep_d     = ~beep_q;
                        end
                    end
                end
                default: begin // SNOOZE
                    if (dismiss) begin
                        state_d = ARMED;
                        cnt_d   = 2'd0;
                    end else if (tick_1hz) begin
                        if (snz_cnt_q == 10'd1) begin
                            state_d    = RINGING;
                            ring_cnt_d = 10'd0;
                            beep_d     = 1'b1;
                        end else begin
                            snz_cnt_d = snz_cnt_q - 10'd1;
                        end
                    end
                end
            endcase
        end
    end

    // State, alarm registers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            alarm_q      <= 16'h0000;
            valid_q      <= 1'b0;
            load_prev_q  <= 1'b0;
            match_prev_q <= 1'b0;
            ring_cnt_q   <= 10'd0;
            snz_cnt_q    <= 10'd0;
            beep_q       <= 1'b0;
            cnt_q        <= 2'd0;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_q      <= alarm_d;
            valid_q      <= valid_d;
            load_prev_q  <= load_alarm;
            match_prev_q <= match;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            beep_q       <= beep_d;
            cnt_q        <= cnt_d;
            buzzer_q     <= (state_d == RINGING) && beep_d;
            ringing_q    <= (state_d == RINGING);
            snoozed_q    <= (state_d == SNOOZE);
        end
    end

    assign buzzer       = buzzer_q;
    assign ringing      = ringing_q;
    assign snoozed      = snoozed_q;
    assign snooze_count = cnt_q;

endmodule
